// File: rtl/ksa_sequencer.sv
// RC4 key-scheduling sequencer: fills the shared S-memory with the identity
// permutation, then shuffles it with the 3-byte key through the single RAM port.
module ksa_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  output logic        busy,
  output logic        done,
  output logic [7:0]  address,
  output logic [7:0]  data,
  output logic        wren,
  input  logic [7:0]  q
);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    READ_SI,
    WAIT_SI,
    CAP_SI,
    READ_SJ,
    WAIT_SJ,
    CAP_SJ,
    WR_SI,
    WR_SJ,
    DONE
  } state_t;

  state_t      state, next_state;
  logic [7:0]  i, j, si, sj;
  logic [1:0]  k;
  logic [23:0] key_r;
  logic        start_q;
  logic        launch;
  logic [7:0]  key_byte;

  assign launch = (state == IDLE) && start && !start_q;

  always_comb begin
    case (k)
      2'd0:    key_byte = key_r[23:16];
      2'd1:    key_byte = key_r[15:8];
      default: key_byte = key_r[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // RAM reads hold the address for READ/WAIT/CAP so q is sampled two edges later.
  always_comb begin
    next_state = state;
    address    = 8'd0;
    data       = 8'd0;
    wren       = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE:    if (launch) next_state = INIT;
      INIT: begin
        address = i;
        data    = i;
        wren    = 1'b1;
        if (i == 8'hFF) next_state = READ_SI;
      end
      READ_SI: begin address = i; next_state = WAIT_SI; end
      WAIT_SI: begin address = i; next_state = CAP_SI;  end
      CAP_SI:  begin address = i; next_state = READ_SJ; end
      READ_SJ: begin address = j; next_state = WAIT_SJ; end
      WAIT_SJ: begin address = j; next_state = CAP_SJ;  end
      CAP_SJ:  begin address = j; next_state = WR_SI;   end
      WR_SI: begin
        address    = i;
        data       = sj;
        wren       = 1'b1;
        next_state = WR_SJ;
      end
      WR_SJ: begin
        address    = j;
        data       = si;
        wren       = 1'b1;
        next_state = (i == 8'hFF) ? DONE : READ_SI;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath; i wraps 255->0 naturally at the end of INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i       <= 8'd0;
      j       <= 8'd0;
      k       <= 2'd0;
      si      <= 8'd0;
      sj      <= 8'd0;
      key_r   <= 24'd0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (launch) begin
            key_r <= secret_key;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 2'd0;
          end
        end
        INIT:   i <= i + 8'd1;
        CAP_SI: begin
          si <= q;
          j  <= j + q + key_byte;
        end
        CAP_SJ: sj <= q;
        WR_SJ: begin
          if (i != 8'hFF) begin
            i <= i + 8'd1;
            k <= (k == 2'd2) ? 2'd0 : k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_sequencer.sv
// Bench for ksa_sequencer: RAM model with 2-edge read latency, a software RC4 KSA
// model driving per-cycle expectations, and directed runs with literal write checks.
module tb_ksa_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic        busy, done, wren;
  logic [7:0]  address, data, q;

  int vectors     = 0;
  int miscompares = 0;

  ksa_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .busy       (busy),
    .done       (done),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .q          (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: address latched at edge e, q valid only while sampling edge e+2 of a held read.
  logic [7:0] mem [256];
  logic [7:0] a1, a2;
  logic       rd1 = 1'b0, rd2 = 1'b0;

  always @(posedge clk) begin
    if (wren) mem[address] <= data;
    a1  <= address;
    a2  <= a1;
    rd1 <= !wren;
    rd2 <= rd1;
  end

  assign q = (rd1 && rd2 && (a1 == a2)) ? mem[a2] : 8'bx;

  // Software KSA: per-iteration j, S[i] and S[j] before the swap, and final S.
  int jn [256];
  int sival [256];
  int sjval [256];
  int s_fin [256];

  function automatic void build_model(input logic [23:0] key);
    int s [256];
    int jj;
    int kb;
    jj = 0;
    for (int n = 0; n < 256; n++) s[n] = n;
    for (int g = 0; g < 256; g++) begin
      kb       = int'((key >> (8 * (2 - (g % 3)))) & 24'hFF);
      jj       = (jj + s[g] + kb) % 256;
      jn[g]    = jj;
      sival[g] = s[g];
      sjval[g] = s[jj];
      s[g]     = sival[g];
      s[g]     = sjval[g];
      s[jj]    = sival[g];
    end
    for (int n = 0; n < 256; n++) s_fin[n] = s[n];
  endfunction

  // Cycle position within a run: 0 idle, 1..2305 running.
  int   m_cyc     = 0;
  logic m_start_q = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc     = 0;
      m_start_q = 1'b0;
    end else begin
      if (m_cyc != 0)
        m_cyc = (m_cyc == 2305) ? 0 : m_cyc + 1;
      else if (start && !m_start_q) begin
        m_cyc = 1;
        build_model(secret_key);
      end
      m_start_q = start;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h", name, m_cyc, actual, expected);
    end
  endtask

  logic check_en = 1'b0;
  int   busy_cnt, done_cnt;
  int   wlog_a[$];
  int   wlog_d[$];

  always @(negedge clk) begin : compare
    int c, g, o;
    if (check_en && !reset) begin
      c = m_cyc;
      checkOutput("busy", {31'd0, busy}, {31'd0, (c >= 1 && c <= 2305)});
      checkOutput("done", {31'd0, done}, {31'd0, (c == 2305)});
      if (c >= 1 && c <= 256) begin
        checkOutput("init_wren", {31'd0, wren}, 32'd1);
        checkOutput("init_addr", {24'd0, address}, c - 1);
        checkOutput("init_data", {24'd0, data}, c - 1);
      end else if (c >= 257 && c <= 2304) begin
        g = (c - 257) / 8;
        o = (c - 257) % 8;
        if (o <= 2) begin
          checkOutput("rd_si_wren", {31'd0, wren}, 32'd0);
          checkOutput("rd_si_addr", {24'd0, address}, g);
        end else if (o <= 5) begin
          checkOutput("rd_sj_wren", {31'd0, wren}, 32'd0);
          checkOutput("rd_sj_addr", {24'd0, address}, jn[g]);
        end else if (o == 6) begin
          checkOutput("wr_si_wren", {31'd0, wren}, 32'd1);
          checkOutput("wr_si_addr", {24'd0, address}, g);
          checkOutput("wr_si_data", {24'd0, data}, sjval[g]);
        end else begin
          checkOutput("wr_sj_wren", {31'd0, wren}, 32'd1);
          checkOutput("wr_sj_addr", {24'd0, address}, jn[g]);
          checkOutput("wr_sj_data", {24'd0, data}, sival[g]);
        end
      end else begin
        checkOutput("idle_wren", {31'd0, wren}, 32'd0);
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (wren === 1'b1) begin
        wlog_a.push_back(int'(address));
        wlog_d.push_back(int'(data));
      end
    end
  end

  task automatic applyStimulus(input logic [23:0] key, input int hold);
    @(negedge clk);
    busy_cnt = 0;
    done_cnt = 0;
    wlog_a.delete();
    wlog_d.delete();
    secret_key = key;
    start      = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkWrite(input int n, input int ea, input int ed);
    if (n + 256 < wlog_a.size()) begin
      checkOutput($sformatf("shuffle_wr%0d_addr", n), wlog_a[n + 256], ea);
      checkOutput($sformatf("shuffle_wr%0d_data", n), wlog_d[n + 256], ed);
    end else
      checkOutput("shuffle_wr_missing", wlog_a.size(), n + 257);
  endtask

  task automatic checkRun();
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("busy_cycles", busy_cnt, 2305);
    checkOutput("write_count", wlog_a.size(), 768);
    checkOutput("back_to_idle", m_cyc, 0);
    for (int n = 0; n < 256; n++)
      checkOutput($sformatf("ram[%0d]", n), {24'd0, mem[n]}, s_fin[n]);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wren"}, {31'd0, wren}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_addr"}, {24'd0, address}, 32'd0);
    checkOutput({tag, "_data"}, {24'd0, data}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    secret_key = 24'd0;
    #1;
    checkResetOutputs("reset");
    #21;
    reset    = 1'b0;
    check_en = 1'b1;

    $display("[TB] key 000000");
    applyStimulus(24'h000000, 1);
    repeat (2312) @(negedge clk);
    checkRun();
    checkWrite(0, 0, 0);
    checkWrite(1, 0, 0);
    checkWrite(2, 1, 1);
    checkWrite(3, 1, 1);
    checkWrite(4, 2, 3);
    checkWrite(5, 3, 2);

    $display("[TB] key 010203");
    applyStimulus(24'h010203, 1);
    repeat (2312) @(negedge clk);
    checkRun();
    checkWrite(0, 0, 1);
    checkWrite(1, 1, 0);

    $display("[TB] key FFFFFF");
    applyStimulus(24'hFFFFFF, 1);
    repeat (2312) @(negedge clk);
    checkRun();
    checkWrite(0, 0, 255);
    checkWrite(1, 255, 0);
    checkWrite(2, 1, 0);
    checkWrite(3, 255, 1);

    $display("[TB] start held high");
    applyStimulus(24'h5A3C96, 6000);
    repeat (5) @(negedge clk);
    checkRun();

    $display("[TB] start pulse and key change while busy");
    applyStimulus(24'h123456, 1);
    repeat (700) @(negedge clk);
    secret_key = 24'hC0FFEE;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1700) @(negedge clk);
    checkRun();

    $display("[TB] async reset mid-run");
    applyStimulus(24'hABCDEF, 1);
    repeat (999) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkResetOutputs("midrun_reset");
    @(negedge clk);
    #2;
    reset = 1'b0;
    applyStimulus(24'h0F1E2D, 1);
    repeat (2312) @(negedge clk);
    checkRun();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
